// File: rtl/core_idex_reg.sv
// core_idex_reg: ID/EX pipeline register with a 2-entry skid buffer.
// The main entry feeds the execute stage. The skid entry absorbs one bundle
// when execute stalls, so id_ready_o can come straight from a flop.
// Held and captured operands snoop the writeback port, so they always carry
// current register data.
// Optional feature: define CORE_IDEX_PERF_EN to add stall and flush counters.
module core_idex_reg #(
    parameter int XLEN    = 64,
    parameter int PC_W    = 64,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               id_valid_i,
    output logic               id_ready_o,
    input  logic [PC_W-1:0]    id_pc_i,
    input  logic [31:0]        id_instr_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [6:0]         id_funct7_i,
    input  logic [2:0]         id_funct3_i,
    input  logic [RFIDX_W-1:0] id_rd_idx_i,
    input  logic [RFIDX_W-1:0] id_rs1_idx_i,
    input  logic [RFIDX_W-1:0] id_rs2_idx_i,
    input  logic [XLEN-1:0]    id_rs1_data_i,
    input  logic [XLEN-1:0]    id_rs2_data_i,
    input  logic               wb_we_i,
    input  logic [RFIDX_W-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]    wb_data_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [PC_W-1:0]    ex_pc_o,
    output logic [31:0]        ex_instr_o,
    output logic [XLEN-1:0]    ex_imm_o,
    output logic [6:0]         ex_funct7_o,
    output logic [2:0]         ex_funct3_o,
    output logic [RFIDX_W-1:0] ex_rd_idx_o,
    output logic [RFIDX_W-1:0] ex_rs1_idx_o,
    output logic [RFIDX_W-1:0] ex_rs2_idx_o,
    output logic [XLEN-1:0]    ex_rs1_data_o,
    output logic [XLEN-1:0]    ex_rs2_data_o
`ifdef CORE_IDEX_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt_o,
    output logic [31:0]        perf_flush_cnt_o
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [31:0]        instr;
        logic [XLEN-1:0]    imm;
        logic [6:0]         funct7;
        logic [2:0]         funct3;
        logic [RFIDX_W-1:0] rd_idx;
        logic [RFIDX_W-1:0] rs1_idx;
        logic [RFIDX_W-1:0] rs2_idx;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
    } bundle_t;

    logic    r_m_v;
    logic    r_s_v;
    bundle_t r_main;
    bundle_t r_skid;

    bundle_t w_in;
    bundle_t w_in_snp;
    bundle_t w_main_snp;
    bundle_t w_skid_snp;
    logic    w_acc;
    logic    w_fire;
    logic    w_wb_en;

    // Replace operand data whose source index matches the writeback target.
    function automatic bundle_t snoop(input bundle_t b, input logic en,
                                      input logic [RFIDX_W-1:0] idx,
                                      input logic [XLEN-1:0] data);
        bundle_t res;
        res = b;
        if (en && (b.rs1_idx == idx)) res.rs1_data = data;
        if (en && (b.rs2_idx == idx)) res.rs2_data = data;
        return res;
    endfunction

    assign w_acc   = id_valid_i & ~r_s_v;
    assign w_fire  = r_m_v & ex_ready_i;
    // x0 is hardwired, so a writeback to it must never be forwarded.
    assign w_wb_en = wb_we_i & (wb_rd_idx_i != '0);

    // Gather the incoming decode bundle and build snooped views of every source.
    always_comb begin
        w_in          = '0;
        w_in.pc       = id_pc_i;
        w_in.instr    = id_instr_i;
        w_in.imm      = id_imm_i;
        w_in.funct7   = id_funct7_i;
        w_in.funct3   = id_funct3_i;
        w_in.rd_idx   = id_rd_idx_i;
        w_in.rs1_idx  = id_rs1_idx_i;
        w_in.rs2_idx  = id_rs2_idx_i;
        w_in.rs1_data = id_rs1_data_i;
        w_in.rs2_data = id_rs2_data_i;
        w_in_snp      = snoop(w_in, w_wb_en, wb_rd_idx_i, wb_data_i);
        w_main_snp    = snoop(r_main, w_wb_en, wb_rd_idx_i, wb_data_i);
        w_skid_snp    = snoop(r_skid, w_wb_en, wb_rd_idx_i, wb_data_i);
    end

    // Main and skid entries: reset, then flush, then handshake moves and snooping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_v  <= 1'b0;
            r_s_v  <= 1'b0;
            r_main <= '0;
            r_skid <= '0;
        end else if (flush_i) begin
            r_m_v <= 1'b0;
            r_s_v <= 1'b0;
        end else begin
            if (w_acc && (!r_m_v || w_fire)) begin
                r_main <= w_in_snp;
                r_m_v  <= 1'b1;
            end else if (w_fire && r_s_v) begin
                r_main <= w_skid_snp;
                r_s_v  <= 1'b0;
            end else if (w_fire) begin
                r_m_v <= 1'b0;
            end else if (r_m_v) begin
                r_main <= w_main_snp;
            end

            if (w_acc && r_m_v && !w_fire) begin
                r_skid <= w_in_snp;
                r_s_v  <= 1'b1;
            end else if (r_s_v && !w_fire) begin
                r_skid <= w_skid_snp;
            end
        end
    end

    assign id_ready_o    = ~r_s_v;
    assign ex_valid_o    = r_m_v;
    assign ex_pc_o       = r_main.pc;
    assign ex_instr_o    = r_main.instr;
    assign ex_imm_o      = r_main.imm;
    assign ex_funct7_o   = r_main.funct7;
    assign ex_funct3_o   = r_main.funct3;
    assign ex_rd_idx_o   = r_main.rd_idx;
    assign ex_rs1_idx_o  = r_main.rs1_idx;
    assign ex_rs2_idx_o  = r_main.rs2_idx;
    assign ex_rs1_data_o = r_main.rs1_data;
    assign ex_rs2_data_o = r_main.rs2_data;

`ifdef CORE_IDEX_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Count stalled cycles and flushes that actually discard held work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_m_v && !ex_ready_i) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush_i && (r_m_v || r_s_v)) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_stall_cnt;
    assign perf_flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_core_idex_reg.sv
// Bench for core_idex_reg: directed vector table, random run against a
// queue-based reference model, and a perf-counter sequence when
// CORE_IDEX_PERF_EN is defined.
module tb_core_idex_reg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] d1;
        logic [63:0] d2;
    } bun_t;

    typedef struct {
        logic        rst, flush, vld, rdy, we;
        logic [63:0] pc, rs1d, rs2d, wbd;
        logic [4:0]  rs1i, rs2i, wbrd;
        logic        ev, ir, chkz;
        logic [63:0] epc, e1, e2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush_i, id_valid_i, id_ready_o;
    logic [63:0] id_pc_i, id_imm_i, id_rs1_data_i, id_rs2_data_i, wb_data_i;
    logic [31:0] id_instr_i;
    logic [6:0]  id_funct7_i;
    logic [2:0]  id_funct3_i;
    logic [4:0]  id_rd_idx_i, id_rs1_idx_i, id_rs2_idx_i, wb_rd_idx_i;
    logic        wb_we_i, ex_valid_o, ex_ready_i;
    logic [63:0] ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o;
    logic [31:0] ex_instr_o;
    logic [6:0]  ex_funct7_o;
    logic [2:0]  ex_funct3_o;
    logic [4:0]  ex_rd_idx_o, ex_rs1_idx_o, ex_rs2_idx_o;
`ifdef CORE_IDEX_PERF_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_idex_reg dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_pc_i(id_pc_i), .id_instr_i(id_instr_i), .id_imm_i(id_imm_i),
        .id_funct7_i(id_funct7_i), .id_funct3_i(id_funct3_i),
        .id_rd_idx_i(id_rd_idx_i), .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .wb_we_i(wb_we_i), .wb_rd_idx_i(wb_rd_idx_i), .wb_data_i(wb_data_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_instr_o(ex_instr_o), .ex_imm_o(ex_imm_o),
        .ex_funct7_o(ex_funct7_o), .ex_funct3_o(ex_funct3_o),
        .ex_rd_idx_o(ex_rd_idx_o), .ex_rs1_idx_o(ex_rs1_idx_o), .ex_rs2_idx_o(ex_rs2_idx_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o)
`ifdef CORE_IDEX_PERF_EN
        , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic rd,
                         input bun_t b, input logic we, input logic [4:0] wrd,
                         input logic [63:0] wd);
        rst = r; flush_i = f; id_valid_i = v; ex_ready_i = rd;
        id_pc_i = b.pc; id_instr_i = b.instr; id_imm_i = b.imm;
        id_funct7_i = b.f7; id_funct3_i = b.f3; id_rd_idx_i = b.rd;
        id_rs1_idx_i = b.rs1; id_rs2_idx_i = b.rs2;
        id_rs1_data_i = b.d1; id_rs2_data_i = b.d2;
        wb_we_i = we; wb_rd_idx_i = wrd; wb_data_i = wd;
    endtask

    function automatic bun_t mkb(input logic [63:0] pc, input logic [4:0] r1i,
                                 input logic [63:0] r1d, input logic [4:0] r2i,
                                 input logic [63:0] r2d);
        bun_t b;
        b.pc = pc; b.instr = pc[31:0] ^ 32'h13; b.imm = pc + 64'd1;
        b.f7 = pc[6:0]; b.f3 = pc[2:0]; b.rd = r1i + 5'd1;
        b.rs1 = r1i; b.rs2 = r2i; b.d1 = r1d; b.d2 = r2d;
        return b;
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic rd,
                                input logic [63:0] pc, input logic [4:0] r1i, input logic [63:0] r1d,
                                input logic [4:0] r2i, input logic [63:0] r2d,
                                input logic we, input logic [4:0] wrd, input logic [63:0] wd,
                                input logic ev, input logic ir, input logic cz,
                                input logic [63:0] epc, input logic [63:0] e1, input logic [63:0] e2);
        vec_t t;
        t.rst = r; t.flush = f; t.vld = v; t.rdy = rd; t.pc = pc;
        t.rs1i = r1i; t.rs1d = r1d; t.rs2i = r2i; t.rs2d = r2d;
        t.we = we; t.wbrd = wrd; t.wbd = wd;
        t.ev = ev; t.ir = ir; t.chkz = cz; t.epc = epc; t.e1 = e1; t.e2 = e2;
        return t;
    endfunction

    // Reference model: ordered list of held bundles, front is what execute sees.
    bun_t q[$];
    logic rz;

    function automatic bun_t msnoop(input bun_t b, input logic we, input logic [4:0] wrd,
                                    input logic [63:0] wd);
        bun_t o;
        o = b;
        if (we && wrd != 5'd0) begin
            if (b.rs1 == wrd) o.d1 = wd;
            if (b.rs2 == wrd) o.d2 = wd;
        end
        return o;
    endfunction

    task automatic model_check();
        chk("rnd_ex_valid", {63'd0, ex_valid_o}, {63'd0, q.size() > 0});
        chk("rnd_id_ready", {63'd0, id_ready_o}, {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("rnd_pc", ex_pc_o, q[0].pc);
            chk("rnd_instr", {32'd0, ex_instr_o}, {32'd0, q[0].instr});
            chk("rnd_imm", ex_imm_o, q[0].imm);
            chk("rnd_f7f3", {54'd0, ex_funct7_o, ex_funct3_o}, {54'd0, q[0].f7, q[0].f3});
            chk("rnd_idx", {49'd0, ex_rd_idx_o, ex_rs1_idx_o, ex_rs2_idx_o},
                {49'd0, q[0].rd, q[0].rs1, q[0].rs2});
            chk("rnd_rs1_data", ex_rs1_data_o, q[0].d1);
            chk("rnd_rs2_data", ex_rs2_data_o, q[0].d2);
        end else if (rz) begin
            chk("rnd_zero_pc", ex_pc_o, 64'd0);
            chk("rnd_zero_rs1", ex_rs1_data_o, 64'd0);
        end
    endtask

    vec_t tv[$];

    initial begin
        bun_t b;
        logic r, f, v, rd, we, ready_m;
        logic [4:0] wrd;
        logic [63:0] wd;

        //          rst fl vld rdy pc        r1i r1d     r2i r2d   we wrd wbd       ev ir cz epc       e1        e2
        tv.push_back(mk(1, 0, 1, 1, 64'h1000, 1, 64'hA,  2, 64'hB, 0, 0, 0,        0, 1, 1, 64'h0,    64'h0,    64'h0));
        tv.push_back(mk(1, 0, 1, 1, 64'h1000, 1, 64'hA,  2, 64'hB, 0, 0, 0,        0, 1, 1, 64'h0,    64'h0,    64'h0));
        tv.push_back(mk(0, 0, 1, 1, 64'h1000, 1, 64'hA,  2, 64'hB, 0, 0, 0,        1, 1, 0, 64'h1000, 64'hA,    64'hB));
        tv.push_back(mk(0, 0, 1, 1, 64'h1004, 1, 64'hC,  2, 64'hD, 0, 0, 0,        1, 1, 0, 64'h1004, 64'hC,    64'hD));
        tv.push_back(mk(0, 0, 1, 1, 64'h1008, 1, 64'hE,  2, 64'hF, 0, 0, 0,        1, 1, 0, 64'h1008, 64'hE,    64'hF));
        tv.push_back(mk(0, 0, 0, 1, 64'h0,    0, 0,      0, 0,     0, 0, 0,        0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 64'h2000, 1, 64'h1,  2, 64'h2, 0, 0, 0,        1, 1, 0, 64'h2000, 64'h1,    64'h2));
        tv.push_back(mk(0, 0, 1, 0, 64'h2004, 1, 64'h3,  2, 64'h4, 0, 0, 0,        1, 0, 0, 64'h2000, 64'h1,    64'h2));
        tv.push_back(mk(0, 0, 1, 0, 64'h2008, 1, 64'h5,  2, 64'h6, 0, 0, 0,        1, 0, 0, 64'h2000, 64'h1,    64'h2));
        tv.push_back(mk(0, 0, 1, 1, 64'h2008, 1, 64'h5,  2, 64'h6, 0, 0, 0,        1, 1, 0, 64'h2004, 64'h3,    64'h4));
        tv.push_back(mk(0, 0, 1, 1, 64'h2008, 1, 64'h5,  2, 64'h6, 0, 0, 0,        1, 1, 0, 64'h2008, 64'h5,    64'h6));
        tv.push_back(mk(0, 0, 0, 1, 64'h0,    0, 0,      0, 0,     0, 0, 0,        0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 64'h3000, 1, 64'h7,  2, 64'h8, 0, 0, 0,        1, 1, 0, 64'h3000, 64'h7,    64'h8));
        tv.push_back(mk(0, 0, 1, 0, 64'h3004, 1, 64'h7,  2, 64'h8, 0, 0, 0,        1, 0, 0, 64'h3000, 64'h7,    64'h8));
        tv.push_back(mk(0, 1, 1, 0, 64'h3008, 1, 64'h7,  2, 64'h8, 0, 0, 0,        0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 64'h0,    0, 0,      0, 0,     0, 0, 0,        0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 64'h4000, 5, 64'h11, 0, 64'h22,0, 0, 0,        1, 1, 0, 64'h4000, 64'h11,   64'h22));
        tv.push_back(mk(0, 0, 0, 0, 64'h0,    0, 0,      0, 0,     1, 5, 64'hABCD, 1, 1, 0, 64'h4000, 64'hABCD, 64'h22));
        tv.push_back(mk(0, 0, 0, 0, 64'h0,    0, 0,      0, 0,     1, 0, 64'h5555, 1, 1, 0, 64'h4000, 64'hABCD, 64'h22));
        tv.push_back(mk(0, 0, 0, 1, 64'h0,    0, 0,      0, 0,     0, 0, 0,        0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 64'h5000, 3, 64'h33, 7, 64'h1, 1, 7, 64'h99,   1, 1, 0, 64'h5000, 64'h33,   64'h99));
        tv.push_back(mk(0, 0, 1, 0, 64'h5004, 7, 64'h2,  8, 64'h3, 0, 0, 0,        1, 0, 0, 64'h5000, 64'h33,   64'h99));
        tv.push_back(mk(0, 0, 0, 0, 64'h0,    0, 0,      0, 0,     1, 7, 64'h77,   1, 0, 0, 64'h5000, 64'h33,   64'h77));
        tv.push_back(mk(0, 0, 0, 1, 64'h0,    0, 0,      0, 0,     1, 8, 64'h88,   1, 1, 0, 64'h5004, 64'h77,   64'h88));
        tv.push_back(mk(0, 0, 0, 1, 64'h0,    0, 0,      0, 0,     0, 0, 0,        0, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 64'h6000, 9, 64'h1,  9, 64'h2, 1, 9, 64'h9999, 1, 1, 0, 64'h6000, 64'h9999, 64'h9999));
        tv.push_back(mk(1, 0, 1, 0, 64'h7000, 1, 64'h1,  2, 64'h2, 0, 0, 0,        0, 1, 1, 64'h0,    64'h0,    64'h0));

        drive(1, 0, 0, 0, '0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].flush, tv[i].vld, tv[i].rdy,
                  mkb(tv[i].pc, tv[i].rs1i, tv[i].rs1d, tv[i].rs2i, tv[i].rs2d),
                  tv[i].we, tv[i].wbrd, tv[i].wbd);
            @(negedge clk);
            chk($sformatf("vec%0d_ex_valid", i), {63'd0, ex_valid_o}, {63'd0, tv[i].ev});
            chk($sformatf("vec%0d_id_ready", i), {63'd0, id_ready_o}, {63'd0, tv[i].ir});
            if (tv[i].ev || tv[i].chkz) begin
                chk($sformatf("vec%0d_pc", i), ex_pc_o, tv[i].epc);
                chk($sformatf("vec%0d_rs1_data", i), ex_rs1_data_o, tv[i].e1);
                chk($sformatf("vec%0d_rs2_data", i), ex_rs2_data_o, tv[i].e2);
            end
        end

        // Last vector was a reset, so the model starts empty with zeroed outputs.
        q.delete();
        rz = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            model_check();
            r  = ($urandom_range(0, 99) == 0);
            f  = ($urandom_range(0, 15) == 0);
            v  = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 1) == 1);
            wrd = 5'($urandom_range(0, 7));
            wd  = {$urandom, $urandom};
            b.pc = {$urandom, $urandom}; b.instr = $urandom; b.imm = {$urandom, $urandom};
            b.f7 = 7'($urandom); b.f3 = 3'($urandom); b.rd = 5'($urandom);
            b.rs1 = 5'($urandom_range(0, 7)); b.rs2 = 5'($urandom_range(0, 7));
            b.d1 = {$urandom, $urandom}; b.d2 = {$urandom, $urandom};
            drive(r, f, v, rd, b, we, wrd, wd);
            ready_m = (q.size() < 2);
            @(posedge clk);
            if (r) begin
                q.delete();
                rz = 1'b1;
            end else if (f) begin
                q.delete();
            end else begin
                if (q.size() > 0 && rd) void'(q.pop_front());
                if (v && ready_m) begin
                    q.push_back(b);
                    rz = 1'b0;
                end
                foreach (q[k]) q[k] = msnoop(q[k], we, wrd, wd);
            end
            @(negedge clk);
        end
        model_check();

`ifdef CORE_IDEX_PERF_EN
        drive(1, 0, 0, 0, '0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 1, 0, mkb(64'h8000, 1, 64'h1, 2, 64'h2), 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, '0, 0, 0, 0);
        repeat (4) @(negedge clk);
        chk("perf_stall_4", {32'd0, perf_stall_cnt_o}, 64'd4);
        chk("perf_flush_0", {32'd0, perf_flush_cnt_o}, 64'd0);
        drive(0, 1, 0, 0, '0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, '0, 0, 0, 0);
        @(negedge clk);
        chk("perf_flush_1", {32'd0, perf_flush_cnt_o}, 64'd1);
        chk("perf_stall_hold", {32'd0, perf_stall_cnt_o}, 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_idex_reg.md
Name: core_idex_reg

Overview:
- ID/EX pipeline register with valid/ready handshake, directly downstream of the decode stage.
- Captures the decoded bundle (pc, instr, imm, funct fields, register indices, operand data) and presents it to the execute stage.
- A 2-entry skid buffer keeps id_ready_o fully registered.
- Held operands snoop the writeback port, so a stalled entry never carries stale register data.

Parameters:
- XLEN, 64, operand/imm data width
- PC_W, 64, program counter width
- RFIDX_W, 5, register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard all held entries (trap/redirect)
- id_valid_i  in  1  decode bundle valid
- id_ready_o  out  1  register can accept; equals !skid_valid, registered
- id_pc_i  in  PC_W  decoded pc
- id_instr_i  in  32  instruction word
- id_imm_i  in  XLEN  immediate
- id_funct7_i  in  7  instr[31:25]
- id_funct3_i  in  3  instr[14:12]
- id_rd_idx_i  in  RFIDX_W  destination index
- id_rs1_idx_i  in  RFIDX_W  source 1 index
- id_rs2_idx_i  in  RFIDX_W  source 2 index
- id_rs1_data_i  in  XLEN  source 1 data
- id_rs2_data_i  in  XLEN  source 2 data
- wb_we_i  in  1  writeback write enable
- wb_rd_idx_i  in  RFIDX_W  writeback destination
- wb_data_i  in  XLEN  writeback data
- ex_valid_o  out  1  main entry valid
- ex_ready_i  in  1  execute accepts
- ex_pc_o, ex_instr_o, ex_imm_o, ex_funct7_o, ex_funct3_o, ex_rd_idx_o, ex_rs1_idx_o, ex_rs2_idx_o, ex_rs1_data_o, ex_rs2_data_o  out  (widths as inputs)  main entry fields, all registered

Behaviour:
- State: main entry (m_v plus bundle), skid entry (s_v plus bundle). acc = id_valid_i & id_ready_o; fire = m_v & ex_ready_i.
- Reset (rst=1 at edge): m_v=0, s_v=0, all bundle fields 0. Hence ex_valid_o=0, id_ready_o=1 and all ex_* outputs 0 on the first cycle after reset. Reset overrides every other input, including mid-transfer.
- Priority each edge: rst > flush_i > handshake.
- flush_i=1: m_v<=0, s_v<=0. The incoming bundle is dropped even if acc=1. Data fields may hold old values; they are don't-care while invalid.
- Handshake transitions, evaluated when no reset or flush:
  - acc & (!m_v | fire): main <= incoming. Latency 1 cycle.
  - acc & m_v & !fire: skid <= incoming, s_v<=1. id_ready_o drops next cycle.
  - fire & s_v: main <= skid, s_v<=0. No acc is possible in this case, since id_ready_o=0.
  - fire & !acc & !s_v: m_v<=0.
- Throughput: 1 bundle/cycle while ex_ready_i=1. Bundles are never dropped or duplicated outside flush. Order is preserved.
- Full: s_v=1 forces id_ready_o=0. Empty: m_v=0 forces ex_valid_o=0.
- Writeback snoop applies when wb_we_i=1 and wb_rd_idx_i!=0:
  - For each valid held entry (main and skid): if rs1_idx==wb_rd_idx_i then rs1_data<=wb_data_i; same for rs2.
  - The same rule applies to a bundle being captured this edge, from id_* or from skid→main: wb_data_i replaces the captured data.
  - rs1 and rs2 both matching: both update.
  - wb_rd_idx_i==0 never updates.
- Snoop never changes valid bits, indices, or handshake state.
- All outputs come straight from flops; no combinational path from ex_ready_i to id_ready_o.

Optional Feature:
- Macro CORE_IDEX_PERF_EN.
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o increments each cycle with m_v & !ex_ready_i.
  - perf_flush_cnt_o increments each cycle with flush_i=1 while m_v|s_v.
  - Both counters reset to 0 on rst and wrap modulo 2^32.
- Undefined: ports and counters are absent. Core behaviour is identical either way.

Test Plan:
- Reset: hold rst 2 cycles with id_valid_i=1 → ex_valid_o=0, id_ready_o=1, ex_pc_o=0. After release, bundle pc=0x1000 appears 1 cycle later with ex_valid_o=1.
- Streaming: ex_ready_i=1, send pc 0x1000,0x1004,0x1008 back-to-back → outputs the same sequence, one per cycle, id_ready_o stays 1.
- Backpressure: ex_ready_i=0 and send 3 bundles.
  - First → main; second → skid; id_ready_o=0.
  - Third is held by source.
  - Raise ex_ready_i → order 1,2,3 with no loss.
- Flush: main and skid both valid, assert flush_i with id_valid_i=1 → next cycle ex_valid_o=0, id_ready_o=1, incoming bundle dropped.
- Snoop while stalled: main holds rs1_idx=5 rs1_data=0x11, ex_ready_i=0.
  - wb_we_i=1, rd=5, data=0xABCD → ex_rs1_data_o=0xABCD next cycle.
  - Same with rd=0 → data unchanged.
- Capture bypass: incoming rs2_idx=7, rs2_data=0x1, same-cycle wb rd=7 data=0x99 → ex_rs2_data_o=0x99. With CORE_IDEX_PERF_EN, 4 stalled cycles → perf_stall_cnt_o=4.
